// File: rtl/uart_bram_loader.sv
// Host command parser: decodes 'W'/'R' burst frames from the UART onto a single-port BRAM.
// Define UART_BRAM_LOADER_ACK_EN to send 0x06 to the host after each completed write burst.
module uart_bram_loader #(
    parameter int LEN    = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    input  logic [7:0]        mem_dout,
    output logic              busy
);

    if (ADDR_W != $clog2(LEN)) begin : g_param_check
        $error("uart_bram_loader: ADDR_W must equal clog2(LEN)");
    end

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR_H   = 4'd1;
    localparam logic [3:0] S_ADDR_L   = 4'd2;
    localparam logic [3:0] S_COUNT    = 4'd3;
    localparam logic [3:0] S_WDATA    = 4'd4;
    localparam logic [3:0] S_RD_ISSUE = 4'd5;
    localparam logic [3:0] S_RD_WAIT  = 4'd6;
    localparam logic [3:0] S_RD_SEND  = 4'd7;
    localparam logic [3:0] S_ACK      = 4'd8;

    localparam logic [7:0]        CMD_WRITE = 8'h57;
    localparam logic [7:0]        CMD_READ  = 8'h52;
    localparam logic [7:0]        ACK_BYTE  = 8'h06;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    logic [3:0]        state_q,     state_d;
    logic              is_read_q,   is_read_d;
    logic [7:0]        addr_hi_q,   addr_hi_d;
    logic [ADDR_W-1:0] cur_q,       cur_d;
    logic [8:0]        remaining_q, remaining_d;
    logic              tx_valid_q,  tx_valid_d;
    logic [7:0]        tx_data_q,   tx_data_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]        mem_din_q,   mem_din_d;
    logic              mem_we_q,    mem_we_d;

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        addr_hi_d   = addr_hi_q;
        cur_d       = cur_q;
        remaining_d = remaining_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == CMD_WRITE) begin
                    is_read_d = 1'b0;
                    state_d   = S_ADDR_H;
                end else if (rx_valid && rx_data == CMD_READ) begin
                    is_read_d = 1'b1;
                    state_d   = S_ADDR_H;
                end
            end
            S_ADDR_H: begin
                if (rx_valid) begin
                    addr_hi_d = rx_data;
                    state_d   = S_ADDR_L;
                end
            end
            S_ADDR_L: begin
                if (rx_valid) begin
                    cur_d   = ADDR_W'({addr_hi_q, rx_data});
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (rx_valid) begin
                    // A count byte of zero encodes a full 256-byte burst.
                    remaining_d = {(rx_data == 8'd0), rx_data};
                    if (is_read_q) begin
                        mem_addr_d = cur_q;
                        state_d    = S_RD_ISSUE;
                    end else begin
                        state_d    = S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                // Stay here for the cycle carrying the last write pulse, then leave.
                if (remaining_q == 9'd0) begin
`ifdef UART_BRAM_LOADER_ACK_EN
                    tx_data_d  = ACK_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = S_ACK;
`else
                    state_d    = S_IDLE;
`endif
                end else if (rx_valid) begin
                    mem_we_d    = 1'b1;
                    mem_din_d   = rx_data;
                    mem_addr_d  = cur_q;
                    cur_d       = cur_q + ADDR_ONE;
                    remaining_d = remaining_q - 9'd1;
                end
            end
            S_RD_ISSUE: begin
                mem_addr_d = cur_q;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                tx_data_d  = mem_dout;
                tx_valid_d = 1'b1;
                state_d    = S_RD_SEND;
            end
            S_RD_SEND: begin
                if (tx_ready) begin
                    // Present the next address now so the BRAM read overlaps RD_ISSUE.
                    tx_valid_d  = 1'b0;
                    cur_d       = cur_q + ADDR_ONE;
                    mem_addr_d  = cur_q + ADDR_ONE;
                    remaining_d = remaining_q - 9'd1;
                    state_d     = (remaining_q == 9'd1) ? S_IDLE : S_RD_ISSUE;
                end
            end
            S_ACK: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            is_read_q   <= 1'b0;
            addr_hi_q   <= 8'd0;
            cur_q       <= '0;
            remaining_q <= 9'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            mem_addr_q  <= '0;
            mem_din_q   <= 8'd0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            addr_hi_q   <= addr_hi_d;
            cur_q       <= cur_d;
            remaining_q <= remaining_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bram_loader.sv
// Directed bench for uart_bram_loader with a behavioural 1-cycle-latency BRAM.
// Build with +define+UART_BRAM_LOADER_ACK_EN to exercise the write-acknowledge path.
module tb_uart_bram_loader;

    localparam int LEN    = 2048;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we;
    logic [7:0]        mem_dout;
    logic              busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0]        bram    [LEN] = '{default: 8'hFF};
    logic [7:0]        exp_mem [LEN] = '{default: 8'hFF};
    logic [ADDR_W-1:0] wr_addr_log [$];
    logic [7:0]        wr_data_log [$];
    logic [7:0]        wdata [$];
    int                tx_seen = 0;

    uart_bram_loader #(.LEN(LEN), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_din);
        end
        if (tx_valid) tx_seen++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [ADDR_W-1:0] addr, input int n);
        logic [15:0] a16;
        a16 = 16'(addr);
        send_byte(cmd);
        send_byte(a16[15:8]);
        send_byte(a16[7:0]);
        send_byte(8'(n));
    endtask

    // Sends a 'W' frame with the first n bytes of wdata and checks the resulting BRAM writes.
    task automatic write_burst(input logic [ADDR_W-1:0] addr, input int n, input string name);
        int                base;
        int                seen0;
        logic [ADDR_W-1:0] a;
        logic [15:0]       a16;
        base  = wr_addr_log.size();
        seen0 = tx_seen;
        a16   = 16'(addr);
        send_byte(8'h57);
        total_cnt++; if (busy !== 1'b1) $display("FAIL %s_busy_after_cmd: got %b want 1", name, busy); else pass_cnt++;
        send_byte(a16[15:8]);
        send_byte(a16[7:0]);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(wdata[i]);
            a = addr + ADDR_W'(i);
            exp_mem[a] = wdata[i];
        end
        total_cnt++;
        if (wr_addr_log.size() !== base + n) begin
            $display("FAIL %s_write_count: got %0d want %0d", name, wr_addr_log.size() - base, n);
        end else begin
            pass_cnt++;
            for (int i = 0; i < n; i++) begin
                a = addr + ADDR_W'(i);
                total_cnt++;
                if (wr_addr_log[base+i] !== a || wr_data_log[base+i] !== wdata[i])
                    $display("FAIL %s_write[%0d]: got %h@%h want %h@%h", name, i,
                             wr_data_log[base+i], wr_addr_log[base+i], wdata[i], a);
                else pass_cnt++;
            end
        end
`ifdef UART_BRAM_LOADER_ACK_EN
        begin
            int cyc = 0;
            while (!tx_valid && cyc < 20) begin
                @(posedge clk); #1; cyc++;
            end
            total_cnt++; if (tx_valid !== 1'b1) $display("FAIL %s_ack_valid: got %b want 1", name, tx_valid); else pass_cnt++;
            total_cnt++; if (busy !== 1'b1) $display("FAIL %s_busy_in_ack: got %b want 1", name, busy); else pass_cnt++;
            total_cnt++; if (tx_data !== 8'h06) $display("FAIL %s_ack_data: got %h want 06", name, tx_data); else pass_cnt++;
            tx_ready = 1'b1;
            @(posedge clk); #1;
            tx_ready = 1'b0;
        end
`else
        total_cnt++; if (tx_seen !== seen0) $display("FAIL %s_no_tx: got %0d tx cycles want 0", name, tx_seen - seen0); else pass_cnt++;
`endif
        total_cnt++; if (busy !== 1'b0) $display("FAIL %s_busy_end: got %b want 0", name, busy); else pass_cnt++;
    endtask

    // Sends an 'R' frame and drains n bytes, optionally stalling tx_ready.
    task automatic read_burst(input logic [ADDR_W-1:0] addr, input int n, input bit toggle, input string name);
        logic [7:0]        got [$];
        logic [7:0]        stall_data;
        logic [ADDR_W-1:0] a;
        bit                stalled;
        bit                r;
        int                cyc;
        int                base;
        base    = wr_addr_log.size();
        stalled = 1'b0;
        cyc     = 0;
        send_header(8'h52, addr, n);
        while (got.size() < n && cyc < n * 12 + 100) begin
            r = toggle ? ((cyc % 3) != 0) : 1'b1;
            if (stalled) begin
                total_cnt++;
                if (tx_valid !== 1'b1 || tx_data !== stall_data)
                    $display("FAIL %s_stall_stable: got v=%b d=%h want v=1 d=%h", name, tx_valid, tx_data, stall_data);
                else pass_cnt++;
            end
            stalled    = tx_valid && !r;
            stall_data = tx_data;
            tx_ready   = r;
            if (tx_valid && r) got.push_back(tx_data);
            @(posedge clk); #1;
            cyc++;
        end
        tx_ready = 1'b0;
        total_cnt++;
        if (got.size() !== n) begin
            $display("FAIL %s_byte_count: got %0d want %0d", name, got.size(), n);
        end else begin
            pass_cnt++;
            for (int i = 0; i < n; i++) begin
                a = addr + ADDR_W'(i);
                total_cnt++;
                if (got[i] !== exp_mem[a]) $display("FAIL %s_data[%0d]: got %h want %h", name, i, got[i], exp_mem[a]);
                else pass_cnt++;
            end
        end
        @(posedge clk); #1;
        total_cnt++; if (wr_addr_log.size() !== base) $display("FAIL %s_no_write: got %0d writes want 0", name, wr_addr_log.size() - base); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL %s_busy_end: got %b want 0", name, busy); else pass_cnt++;
    endtask

    task automatic test_reset();
        int cyc;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else pass_cnt++;
        total_cnt++; if (tx_data !== 8'd0) $display("FAIL reset_tx_data: got %h want 00", tx_data); else pass_cnt++;
        total_cnt++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 000", mem_addr); else pass_cnt++;
        total_cnt++; if (mem_din !== 8'd0 || mem_we !== 1'b0) $display("FAIL reset_mem_din_we: got %h/%b want 00/0", mem_din, mem_we); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        rst_n = 1'b1;
        send_header(8'h52, 11'h010, 1);
        cyc = 0;
        while (!tx_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        total_cnt++; if (tx_valid !== 1'b1) $display("FAIL reset_pre_tx_valid: got %b want 1", tx_valid); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (tx_valid !== 1'b0) $display("FAIL async_reset_tx_valid: got %b want 0", tx_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (tx_data !== 8'd0) $display("FAIL async_reset_tx_data: got %h want 00", tx_data); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        wdata = {8'hAA, 8'hBB, 8'hCC};
        write_burst(11'h010, 3, "write");
    endtask

    task automatic test_read_back();
        read_burst(11'h010, 3, 1'b0, "readback");
        read_burst(11'h013, 2, 1'b0, "unwritten");
    endtask

    task automatic test_wrap_backpressure();
        wdata = {8'h11, 8'h22};
        write_burst(11'h7FF, 2, "wrap_write");
        read_burst(11'h7FF, 2, 1'b1, "wrap_read");
    endtask

    task automatic test_junk_cnt0();
        send_byte(8'h00);
        total_cnt++; if (busy !== 1'b0) $display("FAIL junk_00_busy: got %b want 0", busy); else pass_cnt++;
        send_byte(8'h41);
        total_cnt++; if (busy !== 1'b0) $display("FAIL junk_41_busy: got %b want 0", busy); else pass_cnt++;
        wdata.delete();
        for (int i = 0; i < 256; i++) wdata.push_back(8'(i * 7 + 3));
        write_burst(11'h000, 256, "cnt0_write");
        read_burst(11'h000, 256, 1'b0, "cnt0_read");
    endtask

    task automatic test_ack();
        wdata = {8'h5A};
        write_burst(11'h000, 1, "ack");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_back();
        test_wrap_backpressure();
        test_junk_cnt0();
        test_ack();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
